mem_map_utlb: RTL and testbench
===============================

Name: mem_map_utlb

Overview:
- Registered virtual-to-physical address mapper for one CPU port (instruction or data), built on the kseg/useg segment decode.
- Adds a parametrised fully-associative micro-TLB, so mapped accesses (useg, kseg2, kseg3) are translated locally.
- A micro-TLB miss triggers a refill handshake to the shared joint TLB (JTLB); the result is installed with round-robin replacement.
- Sits between the pipeline address stage and the cache/bus interface; one request in flight at a time.

Parameters:
- ENTRIES, 4: micro-TLB entry count; power of two, at least 2.
- WITH_TLB, 1: 0 = mapped segments pass through unchanged, with no refill and no TLB exceptions.
- ASID_W, 8: ASID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  virtual address
- req_write  in  1  store access
- um  in  1  user mode
- asid  in  ASID_W  current ASID
- cp0_kseg0_uncached  in  1  kseg0 cacheability
- flush  in  1  invalidate all micro-TLB entries (TLBWI/TLBWR/ASID change)
- resp_valid  out  1  one-cycle result strobe
- resp_addr  out  32  physical address
- resp_uncached  out  1  uncached access
- resp_addr_err  out  1  user access to addr[31]=1
- resp_refill  out  1  JTLB miss (TLB refill exception)
- resp_tlb_inv  out  1  matched entry has V=0
- resp_mod  out  1  store to entry with D=0
- jtlb_req  out  1  refill request, held until ack
- jtlb_vpn  out  20  VPN (addr[31:12])
- jtlb_asid  out  ASID_W  ASID of request
- jtlb_ack  in  1  refill response strobe
- jtlb_hit  in  1  JTLB match
- jtlb_pfn  in  20  PFN for this 4 KB page
- jtlb_c  in  1  1 = uncached
- jtlb_v, jtlb_d, jtlb_g  in  1 each  valid, dirty, global

Behaviour:
- Reset: state IDLE.
  - All entries invalid; victim pointer = 0.
  - All outputs 0, except req_ready = 1.
- Entry contents: valid, vpn[19:0], asid, g, pfn[19:0], c, v, d; 4 KB granularity.
- Hit condition: valid & vpn == addr[31:12] & (g | asid match). At most one entry hits.
- States: IDLE, REFILL.
- req_ready = (state == IDLE) & !flush.
- IDLE, on request acceptance; resp_valid is asserted the next cycle, with:
  - um & addr[31]: resp_addr_err=1, resp_addr=0, no lookup.
  - kseg0 (100): resp_addr={3'b0,addr[28:0]}, resp_uncached=cp0_kseg0_uncached.
  - kseg1 (101): resp_addr={3'b0,addr[28:0]}, resp_uncached=1.
  - Mapped segment with WITH_TLB=0: resp_addr=addr, resp_uncached=0.
  - Mapped segment, hit: resp_addr={pfn,addr[11:0]}, resp_uncached=c, resp_tlb_inv=!v, resp_mod=req_write&v&!d.
  - Mapped segment, miss: no resp. Latch vpn, asid, offset and write; go to REFILL.
- REFILL:
  - jtlb_req=1, with jtlb_vpn/jtlb_asid stable until jtlb_ack.
  - On jtlb_ack with jtlb_hit=1: install the entry at the victim pointer, victim pointer += 1 (wraps at ENTRIES).
  - Then, the next cycle, assert resp_valid with fields computed from the jtlb_* values; return to IDLE.
  - On jtlb_ack with jtlb_hit=0: no install; the next cycle resp_valid=1 with resp_refill=1, resp_addr=0; return to IDLE.
  - jtlb_req drops in the cycle after ack.
- Latency:
  - Unmapped or hit: 1 cycle.
  - Miss: 1 cycle after jtlb_ack.
  - Back-to-back hits: one per cycle.
- Error responses: exactly one of the error flags is set; resp_addr=0 on addr_err and refill.
- Error installs: entries with V=0 are still installed, so a repeat access reports resp_tlb_inv without refill.
- flush:
  - Clears all valid bits next edge; the victim pointer is unchanged.
  - While asserted, req_ready=0.
  - flush during REFILL: the response is still delivered, but the entry is not installed.
- No backpressure on resp; the consumer must accept resp_valid.
- Reset mid-REFILL: abort; jtlb_req drops asynchronously; any late jtlb_ack is ignored.

Test Plan:
- Reset, then request 0x8000_1234 with cp0_kseg0_uncached=1 -> next cycle resp_addr=0x0000_1234, resp_uncached=1, jtlb_req never asserted.
- um=1, request 0xA000_0000 -> resp_addr_err=1, resp_addr=0, no refill.
- Request 0x0040_0ABC (asid 5, miss) -> jtlb_req with vpn 0x00400; ack hit, pfn 0x12345, v=1, d=1, c=0 -> resp_addr=0x1234_5ABC. Repeat request -> 1-cycle hit, no jtlb_req.
- Store to a page installed with d=0 -> resp_mod=1. Same page with asid 6, g=0 -> miss and refill. Same page with g=1 -> hit.
- Fill ENTRIES+1 distinct pages with ENTRIES=4 -> 5th install overwrites entry 0; first page misses again.
- Miss with jtlb_ack & !jtlb_hit -> resp_refill=1. flush during REFILL -> response delivered, entry not installed; rst_n low mid-REFILL -> jtlb_req=0 immediately.

Source files
------------

// File: rtl/mem_map_utlb_if.sv
// CPU-port bundle for mem_map_utlb: request/response towards the pipeline and
// the refill handshake towards the shared joint TLB.
interface mem_map_utlb_if #(
  parameter int ASID_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_write;
  logic              um;
  logic [ASID_W-1:0] asid;

  logic              resp_valid;
  logic [31:0]       resp_addr;
  logic              resp_uncached;
  logic              resp_addr_err;
  logic              resp_refill;
  logic              resp_tlb_inv;
  logic              resp_mod;

  logic              jtlb_req;
  logic [19:0]       jtlb_vpn;
  logic [ASID_W-1:0] jtlb_asid;
  logic              jtlb_ack;
  logic              jtlb_hit;
  logic [19:0]       jtlb_pfn;
  logic              jtlb_c;
  logic              jtlb_v;
  logic              jtlb_d;
  logic              jtlb_g;

  // master: pipeline plus JTLB, i.e. everything that surrounds the mapper
  modport master (
    output req_valid, req_addr, req_write, um, asid,
    input  req_ready,
    input  resp_valid, resp_addr, resp_uncached, resp_addr_err, resp_refill,
           resp_tlb_inv, resp_mod,
    input  jtlb_req, jtlb_vpn, jtlb_asid,
    output jtlb_ack, jtlb_hit, jtlb_pfn, jtlb_c, jtlb_v, jtlb_d, jtlb_g
  );

  modport slave (
    input  req_valid, req_addr, req_write, um, asid,
    output req_ready,
    output resp_valid, resp_addr, resp_uncached, resp_addr_err, resp_refill,
           resp_tlb_inv, resp_mod,
    output jtlb_req, jtlb_vpn, jtlb_asid,
    input  jtlb_ack, jtlb_hit, jtlb_pfn, jtlb_c, jtlb_v, jtlb_d, jtlb_g
  );
endinterface

// File: rtl/mem_map_utlb.sv
// Registered virtual-to-physical mapper with a fully-associative micro-TLB
// that refills from the joint TLB on a miss (round-robin replacement).
module mem_map_utlb #(
  parameter int ENTRIES  = 4,
  parameter int WITH_TLB = 1,
  parameter int ASID_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cp0_kseg0_uncached,
  input  logic flush,
  mem_map_utlb_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [0:0] {IDLE, REFILL} state_t;

  state_t state, state_next;

  logic [ENTRIES-1:0] ent_valid;
  logic [19:0]        ent_vpn  [ENTRIES];
  logic [ASID_W-1:0]  ent_asid [ENTRIES];
  logic [19:0]        ent_pfn  [ENTRIES];
  logic [ENTRIES-1:0] ent_g;
  logic [ENTRIES-1:0] ent_c;
  logic [ENTRIES-1:0] ent_v;
  logic [ENTRIES-1:0] ent_d;
  logic [IDX_W-1:0]   victim;

  logic [19:0]        lat_vpn;
  logic [ASID_W-1:0]  lat_asid;
  logic [11:0]        lat_off;
  logic               lat_write;
  logic               no_install;

  logic               accept;
  logic               install;
  logic               start_refill;
  logic               lookup_hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [19:0]        req_vpn;
  logic [2:0]         seg;

  logic               rsp_valid_n;
  logic [31:0]        rsp_addr_n;
  logic               rsp_unc_n;
  logic               rsp_err_n;
  logic               rsp_refill_n;
  logic               rsp_inv_n;
  logic               rsp_mod_n;

  logic               resp_valid_q;
  logic [31:0]        resp_addr_q;
  logic               resp_unc_q;
  logic               resp_err_q;
  logic               resp_refill_q;
  logic               resp_inv_q;
  logic               resp_mod_q;

  assign req_vpn       = bus.req_addr[31:12];
  assign seg           = bus.req_addr[31:29];
  assign bus.req_ready = (state == IDLE) && !flush;
  assign accept        = bus.req_valid && bus.req_ready;

  // A flush seen at any point during the refill poisons the install.
  assign install = (state == REFILL) && bus.jtlb_ack && bus.jtlb_hit
                   && !flush && !no_install;

  assign bus.jtlb_req  = (state == REFILL);
  assign bus.jtlb_vpn  = lat_vpn;
  assign bus.jtlb_asid = lat_asid;

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_addr     = resp_addr_q;
  assign bus.resp_uncached = resp_unc_q;
  assign bus.resp_addr_err = resp_err_q;
  assign bus.resp_refill   = resp_refill_q;
  assign bus.resp_tlb_inv  = resp_inv_q;
  assign bus.resp_mod      = resp_mod_q;

  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid[i] && (ent_vpn[i] == req_vpn)
          && (ent_g[i] || (ent_asid[i] == bus.asid))) begin
        lookup_hit = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next   = state;
    start_refill = 1'b0;
    rsp_valid_n  = 1'b0;
    rsp_addr_n   = '0;
    rsp_unc_n    = 1'b0;
    rsp_err_n    = 1'b0;
    rsp_refill_n = 1'b0;
    rsp_inv_n    = 1'b0;
    rsp_mod_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.um && bus.req_addr[31]) begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end else if (seg == 3'b100) begin
            rsp_valid_n = 1'b1;
            rsp_addr_n  = {3'b000, bus.req_addr[28:0]};
            rsp_unc_n   = cp0_kseg0_uncached;
          end else if (seg == 3'b101) begin
            rsp_valid_n = 1'b1;
            rsp_addr_n  = {3'b000, bus.req_addr[28:0]};
            rsp_unc_n   = 1'b1;
          end else if (WITH_TLB == 0) begin
            rsp_valid_n = 1'b1;
            rsp_addr_n  = bus.req_addr;
          end else if (lookup_hit) begin
            rsp_valid_n = 1'b1;
            rsp_addr_n  = {ent_pfn[hit_idx], bus.req_addr[11:0]};
            rsp_unc_n   = ent_c[hit_idx];
            rsp_inv_n   = !ent_v[hit_idx];
            rsp_mod_n   = bus.req_write && ent_v[hit_idx] && !ent_d[hit_idx];
          end else begin
            start_refill = 1'b1;
            state_next   = REFILL;
          end
        end
      end
      REFILL: begin
        if (bus.jtlb_ack) begin
          state_next  = IDLE;
          rsp_valid_n = 1'b1;
          if (bus.jtlb_hit) begin
            rsp_addr_n = {bus.jtlb_pfn, lat_off};
            rsp_unc_n  = bus.jtlb_c;
            rsp_inv_n  = !bus.jtlb_v;
            rsp_mod_n  = lat_write && bus.jtlb_v && !bus.jtlb_d;
          end else begin
            rsp_refill_n = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q  <= 1'b0;
      resp_addr_q   <= '0;
      resp_unc_q    <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_refill_q <= 1'b0;
      resp_inv_q    <= 1'b0;
      resp_mod_q    <= 1'b0;
    end else begin
      resp_valid_q  <= rsp_valid_n;
      resp_addr_q   <= rsp_addr_n;
      resp_unc_q    <= rsp_unc_n;
      resp_err_q    <= rsp_err_n;
      resp_refill_q <= rsp_refill_n;
      resp_inv_q    <= rsp_inv_n;
      resp_mod_q    <= rsp_mod_n;
    end
  end

  // The missed request is held here so the JTLB sees a stable VPN/ASID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_vpn    <= '0;
      lat_asid   <= '0;
      lat_off    <= '0;
      lat_write  <= 1'b0;
      no_install <= 1'b0;
    end else if (start_refill) begin
      lat_vpn    <= req_vpn;
      lat_asid   <= bus.asid;
      lat_off    <= bus.req_addr[11:0];
      lat_write  <= bus.req_write;
      no_install <= 1'b0;
    end else if ((state == REFILL) && flush) begin
      no_install <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_g     <= '0;
      ent_c     <= '0;
      ent_v     <= '0;
      ent_d     <= '0;
      victim    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_vpn[i]  <= '0;
        ent_asid[i] <= '0;
        ent_pfn[i]  <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
    end else if (install) begin
      ent_valid[victim] <= 1'b1;
      ent_vpn[victim]   <= lat_vpn;
      ent_asid[victim]  <= lat_asid;
      ent_pfn[victim]   <= bus.jtlb_pfn;
      ent_g[victim]     <= bus.jtlb_g;
      ent_c[victim]     <= bus.jtlb_c;
      ent_v[victim]     <= bus.jtlb_v;
      ent_d[victim]     <= bus.jtlb_d;
      victim            <= victim + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_map_utlb.sv
// Self-checking bench for mem_map_utlb: directed scenarios with literal
// expectations, then randomized traffic against a page-level reference model.
module tb_mem_map_utlb;

  localparam int ENTRIES = 4;
  localparam int ASID_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cp0_kseg0_uncached = 1'b0;
  logic flush = 1'b0;

  mem_map_utlb_if #(.ASID_W(ASID_W)) bus ();

  mem_map_utlb #(
    .ENTRIES(ENTRIES),
    .WITH_TLB(1),
    .ASID_W(ASID_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cp0_kseg0_uncached(cp0_kseg0_uncached),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [19:0] vpn;
    bit [7:0]  asid;
    bit        g;
    bit [19:0] pfn;
    bit        c;
    bit        v;
    bit        d;
  } ent_t;

  typedef struct {
    bit        valid;
    bit [31:0] addr;
    bit        unc;
    bit        err;
    bit        refill;
    bit        inv;
    bit        mod;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  ent_t      m_tlb [ENTRIES];
  int        m_ptr;
  int        m_hit;
  bit        m_busy;
  bit        m_noinst;
  bit [19:0] m_vpn;
  bit [7:0]  m_asid;
  bit [11:0] m_off;
  bit        m_write;
  bit [31:0] m_addr;
  rsp_t      exp_rsp;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic user,
                               input logic [7:0] a);
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.um        = user;
    bus.asid      = a;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic jtlbAck(input logic hit, input logic [19:0] pfn, input logic c,
                         input logic v, input logic d, input logic g);
    bus.jtlb_hit = hit;
    bus.jtlb_pfn = pfn;
    bus.jtlb_c   = c;
    bus.jtlb_v   = v;
    bus.jtlb_d   = d;
    bus.jtlb_g   = g;
    bus.jtlb_ack = 1'b1;
    step();
    bus.jtlb_ack = 1'b0;
  endtask

  // Synthetic page table the random JTLB responder answers from.
  function automatic void ptLookup(input bit [19:0] vpn, input bit [7:0] a, output bit hit,
                                   output bit [19:0] pfn, output bit c, output bit v,
                                   output bit d, output bit g);
    bit [3:0] idx;
    idx = vpn[3:0];
    hit = (idx != 4'hF);
    g   = idx[0];
    v   = (idx != 4'd3);
    d   = idx[1];
    c   = idx[2];
    pfn = {vpn[19:8] ^ 12'hA5C, vpn[7:0]} ^ (g ? 20'h0 : {a, 12'h000});
  endfunction

  // Reference model: translation rules applied per accepted request / JTLB answer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) m_tlb[i] = '{default: '0};
      m_ptr    = 0;
      m_busy   = 1'b0;
      m_noinst = 1'b0;
      exp_rsp  = '{default: '0};
    end else begin
      exp_rsp = '{default: '0};
      if (m_busy) begin
        if (flush) m_noinst = 1'b1;
        if (bus.jtlb_ack) begin
          m_busy        = 1'b0;
          exp_rsp.valid = 1'b1;
          if (bus.jtlb_hit) begin
            exp_rsp.addr = {bus.jtlb_pfn, m_off};
            exp_rsp.unc  = bus.jtlb_c;
            exp_rsp.inv  = !bus.jtlb_v;
            exp_rsp.mod  = m_write && bus.jtlb_v && !bus.jtlb_d;
            if (!m_noinst) begin
              m_tlb[m_ptr] = '{valid: 1'b1, vpn: m_vpn, asid: m_asid, g: bus.jtlb_g,
                               pfn: bus.jtlb_pfn, c: bus.jtlb_c, v: bus.jtlb_v,
                               d: bus.jtlb_d};
              m_ptr = (m_ptr + 1) % ENTRIES;
            end
          end else begin
            exp_rsp.refill = 1'b1;
          end
        end
      end else if (bus.req_valid && !flush) begin
        m_addr = bus.req_addr;
        if (bus.um && m_addr[31]) begin
          exp_rsp.valid = 1'b1;
          exp_rsp.err   = 1'b1;
        end else if (m_addr[31:29] == 3'b100) begin
          exp_rsp.valid = 1'b1;
          exp_rsp.addr  = m_addr - 32'h8000_0000;
          exp_rsp.unc   = cp0_kseg0_uncached;
        end else if (m_addr[31:29] == 3'b101) begin
          exp_rsp.valid = 1'b1;
          exp_rsp.addr  = m_addr - 32'hA000_0000;
          exp_rsp.unc   = 1'b1;
        end else begin
          m_hit = -1;
          for (int i = 0; i < ENTRIES; i++)
            if (m_tlb[i].valid && m_tlb[i].vpn == m_addr[31:12]
                && (m_tlb[i].g || m_tlb[i].asid == bus.asid)) m_hit = i;
          if (m_hit >= 0) begin
            exp_rsp.valid = 1'b1;
            exp_rsp.addr  = {m_tlb[m_hit].pfn, m_addr[11:0]};
            exp_rsp.unc   = m_tlb[m_hit].c;
            exp_rsp.inv   = !m_tlb[m_hit].v;
            exp_rsp.mod   = bus.req_write && m_tlb[m_hit].v && !m_tlb[m_hit].d;
          end else begin
            m_busy   = 1'b1;
            m_noinst = 1'b0;
            m_vpn    = m_addr[31:12];
            m_asid   = bus.asid;
            m_off    = m_addr[11:0];
            m_write  = bus.req_write;
          end
        end
      end
      if (flush) for (int i = 0; i < ENTRIES; i++) m_tlb[i].valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp_req_ready", 32'(bus.req_ready), 32'(!m_busy && !flush));
      checkOutput("cmp_jtlb_req", 32'(bus.jtlb_req), 32'(m_busy));
      if (m_busy) begin
        checkOutput("cmp_jtlb_vpn", 32'(bus.jtlb_vpn), 32'(m_vpn));
        checkOutput("cmp_jtlb_asid", 32'(bus.jtlb_asid), 32'(m_asid));
      end
      checkOutput("cmp_resp_valid", 32'(bus.resp_valid), 32'(exp_rsp.valid));
      if (exp_rsp.valid) begin
        checkOutput("cmp_resp_addr", bus.resp_addr, exp_rsp.addr);
        checkOutput("cmp_resp_uncached", 32'(bus.resp_uncached), 32'(exp_rsp.unc));
        checkOutput("cmp_resp_addr_err", 32'(bus.resp_addr_err), 32'(exp_rsp.err));
        checkOutput("cmp_resp_refill", 32'(bus.resp_refill), 32'(exp_rsp.refill));
        checkOutput("cmp_resp_tlb_inv", 32'(bus.resp_tlb_inv), 32'(exp_rsp.inv));
        checkOutput("cmp_resp_mod", 32'(bus.resp_mod), 32'(exp_rsp.mod));
      end
    end
  end

  bit        r_hit, r_c, r_v, r_d, r_g;
  bit [19:0] r_pfn;
  bit [3:0]  r_idx;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.um        = 1'b0;
    bus.asid      = '0;
    bus.jtlb_ack  = 1'b0;
    bus.jtlb_hit  = 1'b0;
    bus.jtlb_pfn  = '0;
    bus.jtlb_c    = 1'b0;
    bus.jtlb_v    = 1'b0;
    bus.jtlb_d    = 1'b0;
    bus.jtlb_g    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_jtlb_req", 32'(bus.jtlb_req), 32'd0);
    checkOutput("reset_resp_addr", bus.resp_addr, 32'd0);

    cp0_kseg0_uncached = 1'b1;
    applyStimulus(32'h8000_1234, 1'b0, 1'b0, 8'd5);
    checkOutput("kseg0_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("kseg0_addr", bus.resp_addr, 32'h0000_1234);
    checkOutput("kseg0_uncached", 32'(bus.resp_uncached), 32'd1);
    checkOutput("kseg0_no_jtlb", 32'(bus.jtlb_req), 32'd0);

    applyStimulus(32'hA000_0000, 1'b0, 1'b1, 8'd5);
    checkOutput("adderr_flag", 32'(bus.resp_addr_err), 32'd1);
    checkOutput("adderr_addr", bus.resp_addr, 32'd0);
    checkOutput("adderr_no_jtlb", 32'(bus.jtlb_req), 32'd0);

    applyStimulus(32'h0040_0ABC, 1'b0, 1'b0, 8'd5);
    checkOutput("miss_no_resp", 32'(bus.resp_valid), 32'd0);
    checkOutput("miss_jtlb_req", 32'(bus.jtlb_req), 32'd1);
    checkOutput("miss_jtlb_vpn", 32'(bus.jtlb_vpn), 32'h0_0400);
    checkOutput("miss_jtlb_asid", 32'(bus.jtlb_asid), 32'd5);
    jtlbAck(1'b1, 20'h12345, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("refill_addr", bus.resp_addr, 32'h1234_5ABC);
    checkOutput("refill_jtlb_drop", 32'(bus.jtlb_req), 32'd0);
    applyStimulus(32'h0040_0ABC, 1'b0, 1'b0, 8'd5);
    checkOutput("hit_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("hit_addr", bus.resp_addr, 32'h1234_5ABC);
    checkOutput("hit_no_jtlb", 32'(bus.jtlb_req), 32'd0);

    applyStimulus(32'h0040_1000, 1'b1, 1'b0, 8'd5);
    jtlbAck(1'b1, 20'h00AAA, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("refill_mod", 32'(bus.resp_mod), 32'd1);
    applyStimulus(32'h0040_1000, 1'b1, 1'b0, 8'd5);
    checkOutput("hit_mod", 32'(bus.resp_mod), 32'd1);
    checkOutput("hit_mod_addr", bus.resp_addr, 32'h00AA_A000);
    applyStimulus(32'h0040_1000, 1'b0, 1'b0, 8'd6);
    checkOutput("asid_miss", 32'(bus.jtlb_req), 32'd1);
    jtlbAck(1'b1, 20'h00CCC, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("asid_refill_addr", bus.resp_addr, 32'h00CC_C000);
    applyStimulus(32'h0040_2000, 1'b0, 1'b0, 8'd5);
    jtlbAck(1'b1, 20'h00DDD, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("global_refill_unc", 32'(bus.resp_uncached), 32'd1);
    applyStimulus(32'h0040_2004, 1'b0, 1'b0, 8'd6);
    checkOutput("global_hit_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("global_hit_addr", bus.resp_addr, 32'h00DD_D004);

    // Fifth install lands on entry 0, evicting page 0x00400.
    applyStimulus(32'h0040_3000, 1'b0, 1'b0, 8'd5);
    jtlbAck(1'b1, 20'h00EEE, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("inv_refill_flag", 32'(bus.resp_tlb_inv), 32'd1);
    applyStimulus(32'h0040_3000, 1'b0, 1'b0, 8'd5);
    checkOutput("inv_hit_flag", 32'(bus.resp_tlb_inv), 32'd1);
    checkOutput("inv_hit_no_jtlb", 32'(bus.jtlb_req), 32'd0);
    applyStimulus(32'h0040_0ABC, 1'b0, 1'b0, 8'd5);
    checkOutput("evicted_miss", 32'(bus.jtlb_req), 32'd1);
    jtlbAck(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("jtlb_miss_refill", 32'(bus.resp_refill), 32'd1);
    checkOutput("jtlb_miss_addr", bus.resp_addr, 32'd0);

    applyStimulus(32'h0040_5000, 1'b0, 1'b0, 8'd5);
    flush = 1'b1;
    #1 checkOutput("flush_ready", 32'(bus.req_ready), 32'd0);
    step();
    flush = 1'b0;
    jtlbAck(1'b1, 20'h00FFF, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("flush_resp_addr", bus.resp_addr, 32'h00FF_F000);
    applyStimulus(32'h0040_5000, 1'b0, 1'b0, 8'd5);
    checkOutput("flush_not_installed", 32'(bus.jtlb_req), 32'd1);

    #2 rst_n = 1'b0;
    #1 checkOutput("reset_mid_refill", 32'(bus.jtlb_req), 32'd0);
    bus.jtlb_ack = 1'b1;
    bus.jtlb_hit = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    bus.jtlb_ack = 1'b0;
    checkOutput("late_ack_ignored", 32'(bus.resp_valid), 32'd0);
    checkOutput("late_ack_ready", 32'(bus.req_ready), 32'd1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_idx = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 6));
      bus.req_addr       = {3'($urandom_range(0, 7)), 13'h0010, r_idx, 12'($urandom)};
      bus.req_valid      = ($urandom_range(0, 2) != 0);
      bus.req_write      = 1'($urandom_range(0, 1));
      bus.um             = ($urandom_range(0, 7) == 0);
      bus.asid           = ($urandom_range(0, 1) != 0) ? 8'd5 : 8'd6;
      cp0_kseg0_uncached = 1'($urandom_range(0, 1));
      flush              = ($urandom_range(0, 24) == 0);
      if (bus.jtlb_req && $urandom_range(0, 2) == 0) begin
        ptLookup(bus.jtlb_vpn, bus.jtlb_asid, r_hit, r_pfn, r_c, r_v, r_d, r_g);
        bus.jtlb_hit = r_hit;
        bus.jtlb_pfn = r_pfn;
        bus.jtlb_c   = r_c;
        bus.jtlb_v   = r_v;
        bus.jtlb_d   = r_d;
        bus.jtlb_g   = r_g;
        bus.jtlb_ack = 1'b1;
      end else begin
        bus.jtlb_ack = 1'b0;
      end
      step();
    end
    bus.req_valid = 1'b0;
    bus.jtlb_ack  = 1'b0;
    flush         = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
